nibble_serial_add_ctrl: RTL and testbench
=========================================

Name: nibble_serial_add_ctrl

Overview:
Sequencer that runs a wide add or subtract through one external 4-bit ripple adder slice, one nibble per clock, LSB first. It latches operands, drives the slice operands and carry-in each cycle, captures the slice sum and carry-out, and reports the result with a start/busy/done handshake. Datapath wrappers instantiate this block next to a single 4-bit adder instance so that one slice serves any operand width.

Parameters:
NIBBLES, 4, operand width in nibbles (W = 4*NIBBLES); legal range 1..16; the index counter is at least 1 bit wide.

Ports:
clk  input  1  system clock, all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a new operation; sampled only in IDLE
op_sub  input  1  0 = A+B+C_in; 1 = A-B (B inverted, initial carry forced to 1, C_in ignored)
C_in  input  1  carry-in for an add operation
A  input  W  operand A, captured when start is accepted
B  input  W  operand B, captured when start is accepted
slice_a  output  4  nibble of A to the adder slice
slice_b  output  4  nibble of B (inverted when subtracting) to the adder slice
slice_cin  output  1  carry into the adder slice
slice_s  input  4  sum from the adder slice
slice_c4  input  1  carry-out from the adder slice
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when S/C_out/ovf are final
S  output  W  result register
C_out  output  1  final carry; for subtract, 1 = no borrow
ovf  output  1  signed overflow of the full-width result

Behaviour:
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: busy=0, done=0, S=0, C_out=0, ovf=0, slice_a=0, slice_b=0, slice_cin=0. The internal idx, carry, A and B registers also clear to 0.
- Reset is asynchronous. Asserting rst_n low at any point, including mid-RUN, forces IDLE and all reset values immediately. The partial result is discarded.
- IDLE -> RUN on a clock edge with start=1:
  - latch A_r=A and sub_r=op_sub
  - latch B_r=B when op_sub=0, B_r=~B when op_sub=1
  - carry=(op_sub ? 1 : C_in), idx=0, S=0, C_out=0, ovf=0
- RUN: the slice interface is combinational from the registers:
  - slice_a = A_r[4*idx+3:4*idx]
  - slice_b = B_r[4*idx+3:4*idx]
  - slice_cin = carry
- RUN, each edge: S[4*idx+3:4*idx] <= slice_s, carry <= slice_c4, idx <= idx+1.
- At the edge where idx == NIBBLES-1:
  - C_out <= slice_c4
  - ovf <= (slice_a[3] == slice_b[3]) && (slice_s[3] != slice_a[3]), where slice_b is the post-inversion value
  - state -> DONE
- DONE: done=1 and busy=0 for exactly one cycle, then unconditionally back to IDLE.
- slice_a, slice_b and slice_cin are 0 outside RUN.
- Latency: start sampled at edge 0, nibbles processed at edges 1..NIBBLES, done high between edges NIBBLES and NIBBLES+1. Total NIBBLES+1 cycles from start to done. The next start is accepted at edge NIBBLES+2 at the earliest.
- start in RUN or DONE is ignored. Latched operands are immune to changes on A, B, C_in and op_sub after acceptance.
- start held high continuously gives back-to-back operations, each accepted in IDLE.
- S, C_out and ovf hold their final values after DONE until the next accepted start clears them.
- NIBBLES=1: RUN lasts one edge; all rules above still hold.

Test Plan:
- NIBBLES=4, A=0x1234, B=0x4321, C_in=0, op_sub=0, start for one cycle -> slice_cin sequence 0,0,0,0; done at edge 5; S=0x5555, C_out=0, ovf=0; busy high edges 1..4.
- A=0xFFFF, B=0x0001, C_in=0 -> slice_cin sequence 0,1,1,1; S=0x0000, C_out=1, ovf=0. Repeat with A=0xFFFF, B=0x0000, C_in=1 -> same result.
- A=0x7FFF, B=0x0001, add -> S=0x8000, C_out=0, ovf=1. A=0x8000, B=0x8000 -> S=0x0000, C_out=1, ovf=1.
- op_sub=1, A=0x0005, B=0x0007, C_in=1 -> S=0xFFFE, C_out=0, ovf=0. op_sub=1, A=0x0007, B=0x0005 -> S=0x0002, C_out=1.
- Start an op, then pulse start with different A and B at edges 2 and 5 -> ignored, first result intact. Then hold start high -> second op accepted at edge 6, done again at edge 11.
- Drive rst_n low between edges 2 and 3 of an op -> busy, done, S and slice_* are 0 without waiting for a clock edge. After release, A=0x0F0F, B=0x0101 -> S=0x1010.

Source files
------------

// File: rtl/nibble_serial_add_ctrl.sv
// Serial add/subtract sequencer: runs a W-bit operation through one external 4-bit
// adder slice, one nibble per clock, LSB first, with a start/busy/done handshake.
module nibble_serial_add_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   op_sub,
    input  logic                   C_in,
    input  logic [4*NIBBLES-1:0]   A,
    input  logic [4*NIBBLES-1:0]   B,
    output logic [3:0]             slice_a,
    output logic [3:0]             slice_b,
    output logic                   slice_cin,
    input  logic [3:0]             slice_s,
    input  logic                   slice_c4,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   S,
    output logic                   C_out,
    output logic                   ovf
);

    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                    state_q, state_d;
    logic [IW-1:0]             idx_q;
    logic                      carry_q;
    logic [NIBBLES-1:0][3:0]   a_q;
    logic [NIBBLES-1:0][3:0]   b_q;
    logic [NIBBLES-1:0][3:0]   s_q;
    logic                      c_out_q;
    logic                      ovf_q;
    logic                      accept;
    logic                      last;

    assign accept = (state_q == StIdle) && start;
    assign last   = (idx_q == LastIdx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = (state_q == StRun);
        done      = (state_q == StDone);
        slice_a   = 4'h0;
        slice_b   = 4'h0;
        slice_cin = 1'b0;
        if (state_q == StRun) begin
            slice_a   = a_q[idx_q];
            slice_b   = b_q[idx_q];
            slice_cin = carry_q;
        end
    end

    // Subtraction is A + ~B + 1, so B is stored pre-inverted and the first carry forced high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            idx_q   <= '0;
            carry_q <= op_sub ? 1'b1 : C_in;
            a_q     <= A;
            b_q     <= op_sub ? ~B : B;
            s_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state_q == StRun) begin
            s_q[idx_q] <= slice_s;
            carry_q    <= slice_c4;
            idx_q      <= idx_q + IW'(1);
            if (last) begin
                c_out_q <= slice_c4;
                ovf_q   <= (slice_a[3] == slice_b[3]) && (slice_s[3] != slice_a[3]);
            end
        end
    end

    assign S     = s_q;
    assign C_out = c_out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl (NIBBLES=4) with a behavioural 4-bit adder slice.
module tb_nibble_serial_add_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op_sub;
    logic        C_in;
    logic [15:0] A;
    logic [15:0] B;
    logic [3:0]  slice_a;
    logic [3:0]  slice_b;
    logic        slice_cin;
    logic [3:0]  slice_s;
    logic        slice_c4;
    logic        busy;
    logic        done;
    logic [15:0] S;
    logic        C_out;
    logic        ovf;

    int total;
    int bad;

    nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_sub    (op_sub),
        .C_in      (C_in),
        .A         (A),
        .B         (B),
        .slice_a   (slice_a),
        .slice_b   (slice_b),
        .slice_cin (slice_cin),
        .slice_s   (slice_s),
        .slice_c4  (slice_c4),
        .busy      (busy),
        .done      (done),
        .S         (S),
        .C_out     (C_out),
        .ovf       (ovf)
    );

    // External ripple adder slice
    assign {slice_c4, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {4'h0, slice_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full operation; operands are scrambled right after acceptance.
    task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub, input logic [3:0] exp_cin,
                         input logic [15:0] exp_s, input logic exp_c, input logic exp_ovf);
        @(negedge clk);
        A = a; B = b; C_in = cin; op_sub = sub; start = 1'b1;
        step();
        start = 1'b0; A = ~a; B = ~b; C_in = ~cin; op_sub = ~sub;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL %s busy/done nibble %0d: got %b/%b want 1/0", name, i, busy, done);
            end
            total++;
            if (slice_cin !== exp_cin[i]) begin
                bad++;
                $display("FAIL %s slice_cin nibble %0d: got %b want %b", name, i, slice_cin,
                         exp_cin[i]);
            end
            step();
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s done pulse: got done=%b busy=%b want 1/0", name, done, busy);
        end
        total++;
        if (S !== exp_s || C_out !== exp_c || ovf !== exp_ovf) begin
            bad++;
            $display("FAIL %s result: got S=%h C=%b V=%b want S=%h C=%b V=%b", name, S, C_out,
                     ovf, exp_s, exp_c, exp_ovf);
        end
        step();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || S !== exp_s || C_out !== exp_c || ovf !== exp_ovf) begin
            bad++;
            $display("FAIL %s after done: got done=%b busy=%b S=%h want 0/0 S=%h", name, done,
                     busy, S, exp_s);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; C_in = 1'b0; A = '0; B = '0;
        #2;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || S !== 16'h0 || C_out !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset outputs: got busy=%b done=%b S=%h C=%b V=%b want all 0", busy,
                     done, S, C_out, ovf);
        end
        total++;
        if (slice_a !== 4'h0 || slice_b !== 4'h0 || slice_cin !== 1'b0) begin
            bad++;
            $display("FAIL reset slice: got a=%h b=%h cin=%b want 0", slice_a, slice_b, slice_cin);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        total++;
        if (busy !== 1'b0 || slice_a !== 4'h0) begin
            bad++;
            $display("FAIL idle after reset: got busy=%b slice_a=%h want 0", busy, slice_a);
        end
    endtask

    task automatic test_add();
        do_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 4'b0000, 16'h5555, 1'b0, 1'b0);
        do_op("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'b1110, 16'h0000, 1'b1, 1'b0);
        do_op("add_cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 4'b1111, 16'h0000, 1'b1, 1'b0);
    endtask

    task automatic test_overflow();
        do_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 4'b1110, 16'h8000, 1'b0, 1'b1);
        do_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 1'b0, 4'b0000, 16'h0000, 1'b1, 1'b1);
    endtask

    task automatic test_sub();
        do_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 4'b0001, 16'hFFFE, 1'b0, 1'b0);
        do_op("sub_plain", 16'h0007, 16'h0005, 1'b0, 1'b1, 4'b1111, 16'h0002, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        A = 16'h1234; B = 16'h4321; C_in = 1'b0; op_sub = 1'b0; start = 1'b1;
        step();                                   // edge 0: accepted
        start = 1'b0;
        step();                                   // edge 1
        A = 16'hAAAA; B = 16'h5555; C_in = 1'b1; op_sub = 1'b1; start = 1'b1;
        step();                                   // edge 2: ignored
        start = 1'b0;
        step();                                   // edge 3
        A = 16'h0F0F; B = 16'h0101; C_in = 1'b0; op_sub = 1'b0; start = 1'b1;
        step();                                   // edge 4: enter DONE
        total++;
        if (done !== 1'b1 || S !== 16'h5555 || C_out !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL b2b first result: got done=%b S=%h C=%b V=%b want 1 5555 0 0", done,
                     S, C_out, ovf);
        end
        step();                                   // edge 5: start in DONE ignored
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || S !== 16'h5555) begin
            bad++;
            $display("FAIL b2b idle gap: got busy=%b done=%b S=%h want 0 0 5555", busy, done, S);
        end
        step();                                   // edge 6: second op accepted
        total++;
        if (busy !== 1'b1 || S !== 16'h0000) begin
            bad++;
            $display("FAIL b2b second accept: got busy=%b S=%h want 1 0000", busy, S);
        end
        for (int i = 0; i < 4; i++) step();       // edges 7..10
        start = 1'b0;
        total++;
        if (done !== 1'b1 || S !== 16'h1010 || C_out !== 1'b0) begin
            bad++;
            $display("FAIL b2b second result: got done=%b S=%h C=%b want 1 1010 0", done, S, C_out);
        end
        step();                                   // edge 11
        step();                                   // edge 12: start low, stays idle
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b settle: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        A = 16'h1234; B = 16'h4321; C_in = 1'b0; op_sub = 1'b0; start = 1'b1;
        step();                                   // edge 0
        start = 1'b0;
        step();                                   // edge 1
        step();                                   // edge 2: S holds partial 0x0055
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || S !== 16'h0 || C_out !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL async reset outputs: got busy=%b done=%b S=%h want 0", busy, done, S);
        end
        total++;
        if (slice_a !== 4'h0 || slice_b !== 4'h0 || slice_cin !== 1'b0) begin
            bad++;
            $display("FAIL async reset slice: got a=%h b=%h cin=%b want 0", slice_a, slice_b,
                     slice_cin);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op("post_reset", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 4'b1010, 16'h1010, 1'b0, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_add();
        test_overflow();
        test_sub();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
